// File: rtl/controle_mem_dados_pkg.sv
// rtl/controle_mem_dados_pkg.sv - shared constants and FSM state type for the data-memory controller
package controle_mem_dados_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int MEM_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_ERR,
    S_HALT,
    S_DUMP,
    S_DONE
  } state_t;

endpackage

// File: rtl/controle_mem_dados.sv
// rtl/controle_mem_dados.sv - load/store controller for the 64-word data memory with end-of-program dump
module controle_mem_dados
  import controle_mem_dados_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [MEM_W-1:0]  req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic              halt_req,
  input  logic [MEM_W-1:0]  pc_in,
  output logic              mem_write,
  output logic              mem_read,
  output logic [MEM_W-1:0]  mem_posicao,
  output logic [DATA_W-1:0] mem_dados,
  input  logic [DATA_W-1:0] mem_saida,
  output logic              mem_flag_pc,
  output logic [MEM_W-1:0]  mem_end_atual,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              done
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_resp_rdata;
  logic [MEM_W-1:0]  r_pc;
  logic              r_pend;
  logic              r_resp_valid;
  logic              r_resp_err;

  logic w_in_range;
  logic w_accept;
  logic w_busy;

  assign w_in_range = (req_addr < MEM_W'(DEPTH));
  assign w_busy     = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_ERR);
  // rst_n gates the only input-driven path so every output is 0 while in reset
  assign req_ready  = rst_n && (r_state == S_IDLE) && !halt_req && !r_pend;
  assign w_accept   = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
      r_pc         <= '0;
      r_pend       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      if (halt_req && w_busy) begin
        r_pend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (halt_req || r_pend) begin
            r_state <= S_HALT;
            r_pc    <= pc_in;
            r_pend  <= 1'b0;
          end else if (w_accept) begin
            r_idx   <= req_addr[ADDR_W-1:0];
            r_wdata <= req_wdata;
            if (!w_in_range)  r_state <= S_ERR;
            else if (req_we)  r_state <= S_WRITE;
            else              r_state <= S_READ;
          end
        end
        S_WRITE: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b1;
        end
        S_READ: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= mem_saida;
        end
        S_ERR: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
        end
        S_HALT: begin
          r_state <= S_DUMP;
          r_cnt   <= '0;
        end
        S_DUMP: begin
          if (dump_ready) begin
            if (r_cnt == ADDR_W'(DEPTH - 1)) r_state <= S_DONE;
            else                             r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_err      = r_resp_err;
  assign resp_rdata    = r_resp_rdata;
  assign mem_write     = (r_state == S_WRITE);
  assign mem_read      = (r_state == S_READ) || (r_state == S_DUMP);
  assign mem_posicao   = ((r_state == S_WRITE) || (r_state == S_READ)) ? MEM_W'(r_idx) :
                         (r_state == S_DUMP) ? MEM_W'(r_cnt) : '0;
  assign mem_dados     = (r_state == S_WRITE) ? r_wdata : '0;
  assign mem_flag_pc   = (r_state == S_HALT);
  assign mem_end_atual = (r_state == S_HALT) ? r_pc : '0;
  assign dump_valid    = (r_state == S_DUMP);
  assign dump_addr     = (r_state == S_DUMP) ? r_cnt : '0;
  assign dump_data     = (r_state == S_DUMP) ? mem_saida : '0;
  assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_controle_mem_dados.sv
// tb/tb_controle_mem_dados.sv - scoreboard bench for the data-memory controller
`timescale 1ns/1ps
module tb_controle_mem_dados;
  import controle_mem_dados_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              halt_req = 1'b0;
  logic [31:0]       pc_in = '0;
  logic              mem_write;
  logic              mem_read;
  logic [31:0]       mem_posicao;
  logic [31:0]       mem_dados;
  logic [31:0]       mem_saida;
  logic              mem_flag_pc;
  logic [31:0]       mem_end_atual;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic [5:0]        dump_addr;
  logic [31:0]       dump_data;
  logic              done;

  controle_mem_dados dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .halt_req(halt_req), .pc_in(pc_in),
    .mem_write(mem_write), .mem_read(mem_read), .mem_posicao(mem_posicao),
    .mem_dados(mem_dados), .mem_saida(mem_saida),
    .mem_flag_pc(mem_flag_pc), .mem_end_atual(mem_end_atual),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [64];
  logic [31:0] exp_img [64];
  assign mem_saida = (mem_posicao < 32'd64) ? mem[mem_posicao[5:0]] : 32'h0;
  always @(posedge clk) if (mem_write && mem_posicao < 32'd64) mem[mem_posicao[5:0]] <= mem_dados;

  wire [173:0] w_all_out = {req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_read,
                            mem_posicao, mem_dados, mem_flag_pc, mem_end_atual, dump_valid,
                            dump_addr, dump_data, done};

  typedef struct { logic err; logic [31:0] rdata; int cyc; } resp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  resp_t       resp_q[$];
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] pc_q[$];
  logic [37:0] dump_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  resp_t       e_resp;
  wr_t         e_wr;
  logic [31:0] e_word;
  logic [37:0] e_dump;
  logic        prev_stall = 1'b0;
  logic [37:0] prev_dump  = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) fail_now("resp_unexpected");
        else begin
          e_resp = resp_q.pop_front();
          chk("resp_err", resp_err, e_resp.err);
          chk("resp_rdata", resp_rdata, e_resp.rdata);
          chk("resp_latency", cyc, e_resp.cyc);
        end
      end
      if (mem_write && mem_read) fail_now("strobes_both_high");
      if (mem_write) begin
        if (wr_q.size() == 0) fail_now("mem_write_unexpected");
        else begin
          e_wr = wr_q.pop_front();
          chk("mem_write_posicao", mem_posicao, e_wr.a);
          chk("mem_write_dados", mem_dados, e_wr.d);
        end
      end
      if (mem_read && !dump_valid) begin
        if (rd_q.size() == 0) fail_now("mem_read_unexpected");
        else begin
          e_word = rd_q.pop_front();
          chk("mem_read_posicao", mem_posicao, e_word);
        end
      end
      if (mem_flag_pc) begin
        if (pc_q.size() == 0) fail_now("flag_pc_unexpected");
        else begin
          e_word = pc_q.pop_front();
          chk("mem_end_atual", mem_end_atual, e_word);
        end
      end
      if (dump_valid && prev_stall) chk("dump_stable", {dump_addr, dump_data}, prev_dump);
      if (dump_valid && dump_ready) begin
        if (dump_q.size() == 0) fail_now("dump_unexpected");
        else begin
          e_dump = dump_q.pop_front();
          chk("dump_word", {dump_addr, dump_data}, e_dump);
          chk("dump_posicao", mem_posicao, {26'h0, e_dump[37:32]});
        end
      end
      prev_stall = dump_valid && !dump_ready;
      prev_dump  = {dump_addr, dump_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic err_e, input logic [31:0] rd_e, input bit keep,
                        output int acc_cyc);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    acc_cyc   = -1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) fail_now("req_accept_timeout");
    else begin
      acc_cyc = cyc;
      resp_q.push_back('{err_e, rd_e, cyc + 2});
      if (!err_e && we) begin
        wr_q.push_back('{addr, wd});
        exp_img[addr[5:0]] = wd;
      end
      if (!err_e && !we) rd_q.push_back(addr);
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  int acc[4];
  int a;
  int n;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      exp_img[i] = 32'hA500_0000 | i;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", w_all_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    chk("done_after_reset", done, 0);
    @(posedge clk);
    #1;

    do_req(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, a);
    do_req(1'b0, 32'd5, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, a);
    do_req(1'b0, 32'd64, 32'h0, 1'b1, 32'h0, 1'b0, a);
    do_req(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 32'h0, 1'b0, a);

    for (int i = 0; i < 4; i++) do_req(1'b1, i, 32'h100 + i, 1'b0, 32'h0, 1'b1, acc[i]);
    req_valid = 1'b0;
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 2);

    pc_in = 32'h0000_004C;
    do_req(1'b0, 32'd3, 32'h0, 1'b0, 32'h0000_0103, 1'b0, a);
    halt_req = 1'b1;
    pc_q.push_back(32'h0000_004C);
    for (int i = 0; i < 64; i++) dump_q.push_back({i[5:0], exp_img[i]});
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      dump_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("done_after_dump", done, 1);
    chk("dump_all_words", dump_q.size(), 0);
    chk("flag_pc_seen", pc_q.size(), 0);
    chk("resp_all_seen", resp_q.size(), 0);

    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd7;
    repeat (3) begin
      @(negedge clk);
      chk("ready_in_done", req_ready, 0);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    rst_n = 1'b0;
    #1;
    chk("done_clears_async", done, 0);
    repeat (2) @(posedge clk);
    pc_q.push_back(32'h0000_004C);
    for (int i = 0; i < 64; i++) dump_q.push_back({i[5:0], exp_img[i]});
    dump_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(dump_valid && dump_addr == 6'd30) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("reached_dump_30", {dump_valid, dump_addr}, {1'b1, 6'd30});
    #1;
    rst_n    = 1'b0;
    halt_req = 1'b0;
    #1;
    chk("reset_mid_dump_zero", w_all_out, 0);
    dump_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rerst", req_ready, 1);
    chk("done_after_rerst", done, 0);
    @(posedge clk);
    #1;
    do_req(1'b1, 32'd10, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, a);
    do_req(1'b0, 32'd10, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0, a);
    repeat (4) @(posedge clk);
    #1;
    chk("final_done_low", done, 0);
    chk("queues_empty", {resp_q.size(), wr_q.size(), rd_q.size(), pc_q.size()}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
